// File: rtl/image_pkg.sv
// Shared mode encodings and FSM state type for the image arithmetic block.
package image_pkg;

  typedef enum logic [1:0] {
    MODE_SAT_ADD  = 2'b00,
    MODE_WRAP_ADD = 2'b01,
    MODE_ABS_DIFF = 2'b10,
    MODE_AVG      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StProc = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/pix_alu.sv
// Combinational per-pixel arithmetic: saturating add, modulo add, absolute difference, average.
module pix_alu
  import image_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  mode_e            mode_i,
  output logic [PIX_W-1:0] res_o
);

  logic [PIX_W:0] sum;

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    res_o = '0;
    unique case (mode_i)
      MODE_SAT_ADD:  res_o = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
      MODE_WRAP_ADD: res_o = sum[PIX_W-1:0];
      MODE_ABS_DIFF: res_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
      MODE_AVG:      res_o = sum[PIX_W:1];
      default:       res_o = '0;
    endcase
  end

endmodule

// File: rtl/image_arith.sv
// Loads two images pixel-pair by pixel-pair, combines them into a result image, and exposes
// the result through a registered read port.
module image_arith
  import image_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  pix_a,
  input  logic [PIX_W-1:0]  pix_b,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] pr_cnt_q, pr_cnt_d;
  logic              issued_q, issued_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              done_q, done_d;
  logic [PIX_W-1:0]  rd_data_q;

  logic [PIX_W-1:0]  mem_a [DEPTH];
  logic [PIX_W-1:0]  mem_b [DEPTH];
  logic [PIX_W-1:0]  mem_r [DEPTH];
  logic [PIX_W-1:0]  a_q, b_q, alu_res;

  logic accept;
  logic issue;

  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q == StLoad) || (state_q == StProc);
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign accept   = in_ready && in_valid;
  // One address per PROC cycle until all DEPTH addresses have been issued.
  assign issue    = (state_q == StProc) && !issued_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ld_cnt_d = ld_cnt_q;
    pr_cnt_d = pr_cnt_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StLoad;
          mode_d   = mode_e'(mode);
          ld_cnt_d = '0;
          pr_cnt_d = '0;
          issued_d = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (ld_cnt_q == LastAddr) begin
            state_d  = StProc;
            ld_cnt_d = '0;
            pr_cnt_d = '0;
            issued_d = 1'b0;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      StProc: begin
        if (issue) begin
          pr_cnt_d = pr_cnt_q + 1'b1;
          if (pr_cnt_q == LastAddr) issued_d = 1'b1;
        end
        if (wr_en_q && (wr_addr_q == LastAddr)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      mode_q    <= MODE_SAT_ADD;
      ld_cnt_q  <= '0;
      pr_cnt_q  <= '0;
      issued_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ld_cnt_q  <= ld_cnt_d;
      pr_cnt_q  <= pr_cnt_d;
      issued_q  <= issued_d;
      wr_en_q   <= issue;
      wr_addr_q <= pr_cnt_q;
      done_q    <= done_d;
      rd_data_q <= mem_r[rd_addr];
    end
  end

  // Arrays carry no reset; their contents are only meaningful once rewritten by a job.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_a[ld_cnt_q] <= pix_a;
      mem_b[ld_cnt_q] <= pix_b;
    end
    a_q <= mem_a[pr_cnt_q];
    b_q <= mem_b[pr_cnt_q];
    if (wr_en_q) mem_r[wr_addr_q] <= alu_res;
  end

  pix_alu #(
    .PIX_W (PIX_W)
  ) u_pix_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .mode_i (mode_q),
    .res_o  (alu_res)
  );

endmodule

// File: tb/tb_image_arith.sv
// Directed-vector bench for image_arith; read-port results are checked by a queue-based monitor.
module tb_image_arith;

  localparam int PIX_W  = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  pix_a, pix_b;
  logic              busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_acc = 0;
  int mon_e;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  int exp_q[$];
  int in_a[DEPTH];
  int in_b[DEPTH];
  int exp_r[DEPTH];

  image_arith #(
    .PIX_W  (PIX_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pix_a    (pix_a),
    .pix_b    (pix_b),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every registered read result is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: got %0d with no expected value queued", rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", {24'd0, rd_data}, mon_e);
      end
    end
  end

  task automatic start_job(input logic [1:0] m, input string name);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " in_ready in LOAD"}, in_ready, 1);
    chk({name, " busy in LOAD"}, busy, 1);
  endtask

  task automatic load_pairs(input bit gap, input bit pulse_start, input string name);
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1;
      pix_a    = in_a[k][PIX_W-1:0];
      pix_b    = in_b[k][PIX_W-1:0];
      if (pulse_start && k == 30) begin
        start = 1'b1;
        mode  = 2'b10;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (gap && k != DEPTH - 1) begin
        in_valid = 1'b0;
        pix_a    = 8'hee;
        pix_b    = 8'h11;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    last_acc = cyc;
    chk({name, " in_ready after last pair"}, in_ready, 0);
    chk({name, " busy in PROC"}, busy, 1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({name, " done seen"}, {31'd0, seen}, 1);
    if (seen) begin
      chk({name, " done latency"}, cyc - last_acc, DEPTH + 1);
      @(negedge clk);
      chk({name, " done width"}, done, 0);
      chk({name, " busy after done"}, busy, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic read_sweep(input string name);
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = k[ADDR_W-1:0];
      rd_req  = 1'b1;
      exp_q.push_back(exp_r[k]);
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({name, " read queue drained"}, exp_q.size(), 0);
  endtask

  task automatic run_job(input logic [1:0] m, input bit gap, input bit pulse, input string name);
    int d0;
    d0 = done_cnt;
    start_job(m, name);
    load_pairs(gap, pulse, name);
    wait_done(name);
    read_sweep(name);
    chk({name, " single done"}, done_cnt - d0, 1);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 2'b00;
    in_valid = 1'b0;
    pix_a    = '0;
    pix_b    = '0;
    rd_addr  = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle in_ready", in_ready, 0);

    // Saturating add: 200+100 clips to 255
    for (int k = 0; k < DEPTH; k++) begin in_a[k] = 200; in_b[k] = 100; exp_r[k] = 255; end
    run_job(2'b00, 1'b0, 1'b0, "sat_add");

    // Modulo add: 300 mod 256 = 44
    for (int k = 0; k < DEPTH; k++) begin in_a[k] = 200; in_b[k] = 100; exp_r[k] = 44; end
    run_job(2'b01, 1'b0, 1'b0, "wrap_add");

    // Modulo add k+k with gapped valid and a start pulse (mode 10) mid-load that must be ignored
    for (int k = 0; k < DEPTH; k++) begin in_a[k] = k; in_b[k] = k; exp_r[k] = (2 * k) % 256; end
    run_job(2'b01, 1'b1, 1'b1, "wrap_gap");

    // Absolute difference both directions
    for (int k = 0; k < DEPTH; k++) begin
      in_a[k]  = (k % 2 == 0) ? 10 : 250;
      in_b[k]  = (k % 2 == 0) ? 250 : 10;
      exp_r[k] = 240;
    end
    run_job(2'b10, 1'b0, 1'b0, "abs_diff");

    // Average on a 9-bit sum: (255+254)/2 = 254
    for (int k = 0; k < DEPTH; k++) begin in_a[k] = 255; in_b[k] = 254; exp_r[k] = 254; end
    run_job(2'b11, 1'b0, 1'b0, "avg");

    // Abort during PROC at address 20
    begin
      int d0;
      d0 = done_cnt;
      for (int k = 0; k < DEPTH; k++) begin in_a[k] = 1; in_b[k] = 2; end
      start_job(2'b00, "abort");
      load_pairs(1'b0, 1'b0, "abort");
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort in_ready", in_ready, 0);
      chk("abort done", done, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      chk("abort no done", done_cnt - d0, 0);
      chk("abort idle busy", busy, 0);
    end

    // Full job after abort: |k - 2k| = k
    for (int k = 0; k < DEPTH; k++) begin in_a[k] = k; in_b[k] = 2 * k; exp_r[k] = k; end
    run_job(2'b10, 1'b0, 1'b0, "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_arith.md
IMAGE_ARITH -- requirements
Module: image_arith

Interface
REQ-001 Parameter PIX_W, default 8: bits per pixel.
REQ-002 Parameter DEPTH, default 64: pixels per image; power of two, at least 4.
REQ-003 Parameter ADDR_W, default log2(DEPTH): width of the address and counters.
REQ-004 Port clk, input, 1 bit: the single clock; every register samples on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle request that begins a job.
REQ-007 Port mode, input, 2 bits: operation select, sampled only when start is accepted.
REQ-008 Port in_valid, input, 1 bit: pix_a/pix_b carry a valid pixel pair.
REQ-009 Port in_ready, output, 1 bit: block accepts a pair this cycle.
REQ-010 Port pix_a, input, PIX_W bits: pixel from image A.
REQ-011 Port pix_b, input, PIX_W bits: pixel from image B.
REQ-012 Port busy, output, 1 bit: high in the LOAD and PROC states.
REQ-013 Port done, output, 1 bit: one-cycle pulse when the result image is complete.
REQ-014 Port rd_addr, input, ADDR_W bits: result read address.
REQ-015 Port rd_data, output, PIX_W bits: result pixel at rd_addr, registered.

Function
REQ-016 Storage: three internal DEPTH x PIX_W arrays, A, B and R.
REQ-017 FSM states: IDLE, LOAD, PROC, DONE.
REQ-018 FSM transitions:
- IDLE or DONE with start=1 -> LOAD; mode latched at that edge.
- start is ignored in LOAD and PROC.
REQ-019 LOAD input handshake:
- in_ready=1 only in LOAD.
- A pair is accepted when in_valid and in_ready are both high, and is written to A and B at the load counter.
- The load counter increments on each accepted pair; in_valid low stalls it with no write.
REQ-020 LOAD exit: the edge that accepts pair DEPTH-1 moves the FSM to PROC and clears the counters; no further pair is accepted.
REQ-021 PROC read: issues read addresses 0..DEPTH-1 on consecutive cycles; A/B read data is registered (1-cycle latency).
REQ-022 PROC write: the ALU result for address k is written to R[k] exactly one cycle after address k is issued.
- PROC lasts DEPTH+1 cycles.
- The edge of the final write moves the FSM to DONE with done=1 for exactly one cycle.
REQ-023 Modes, all with PIX_W-bit result (MAX = 2^PIX_W-1):
- 00: saturating add, min(a+b, MAX).
- 01: modulo add, (a+b) mod 2^PIX_W.
- 10: absolute difference, |a-b|.
- 11: average, floor((a+b)/2), computed on a PIX_W+1-bit sum.
REQ-024 Read port: rd_data <= R[rd_addr] every cycle in any state (1-cycle latency). R content is defined only after the first done.
REQ-025 A new start from DONE overwrites A, B and R; R is stale until the next done.

Reset
REQ-026 Reset low asynchronously forces:
- FSM to IDLE;
- load and process counters to 0;
- latched mode to 00;
- in_ready, busy, done and rd_data to 0.
REQ-027 Reset mid-operation (LOAD or PROC) aborts the job with no done pulse. Array contents are not reset and are undefined until rewritten.

Structure
REQ-028 A shared package image_pkg shall hold the mode encodings (MODE_SAT_ADD, MODE_WRAP_ADD, MODE_ABS_DIFF, MODE_AVG) and the FSM state type.
REQ-029 Sub-module pix_alu, purely combinational and parameterised by PIX_W, shall implement REQ-023; the arrays and FSM stay in image_arith.

Verification
REQ-030 Saturating add: mode 00, DEPTH=64, a=200, b=100 for all pixels.
- Expect R[*]=255.
- Expect done exactly 64+1 cycles after the last accept.
REQ-031 Modulo add: mode 01, a=200, b=100.
- Expect R[*]=44.
- Expect a=k, b=k gives R[k]=2k mod 256.
REQ-032 Absolute difference and average:
- mode 10, a=10, b=250 -> R=240; a=250, b=10 -> R=240.
- mode 11, a=255, b=254 -> R=254.
REQ-033 Handshake and start masking:
- in_valid toggles every other cycle -> exactly 64 pairs stored in order.
- start pulsed during LOAD -> ignored, mode unchanged.
REQ-034 Reset mid-operation:
- reset low at PROC address 20 -> state IDLE and busy=0 immediately, no done.
- A following full job -> correct R and a single done.
REQ-035 Read port: after done, sweeping rd_addr 0..63 -> rd_data equals the expected R[k] one cycle later.
